// File: rtl/lsu_align.sv
// lsu_align: load/store alignment unit between the MEM-stage pipeline register
// and a word-organised data memory.
//
// Converts a byte-addressed request (funct3 width/sign) into word-aligned
// accesses with byte enables. A request that straddles a 32-bit word boundary
// is split into two back-to-back accesses, holding the pipeline for one cycle.
// Load bytes are lane-shifted, merged across the two words when split, and
// sign- or zero-extended.
//
// Handshake: a request is presented with req_valid=1. The unit answers in the
// same cycle with done=1, or with stall=1 when a second access is needed. While
// stall=1 the pipeline keeps every req_* input stable. done then rises in the
// following cycle. A new request may be presented in the cycle right after done.
//
// Ports:
//   clk, rst         clock; synchronous active-low reset
//   req_valid        request present this cycle
//   req_write        1 = store, 0 = load
//   req_f3           funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   req_addr         byte address
//   req_wdata        store data
//   stall            hold the pipeline (first half of a split access)
//   done             request completes this cycle
//   err              illegal request; no memory access made
//   load_data        extended load result (only when done && !req_write)
//   split_cnt        saturating count of completed split requests
//   mem_en/mem_we    memory access / write strobe
//   mem_addr         word index
//   mem_be           byte enables, bit i -> bits [8i+7:8i]
//   mem_wdata        lane-aligned write data
//   mem_rdata        combinational read data for mem_addr
module lsu_align #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [2:0]        req_f3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic              done,
    output logic              err,
    output logic [31:0]       load_data,
    output logic [CNT_W-1:0]  split_cnt,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int WORD_W = ADDR_W - 2;

    typedef enum logic {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } state_t;

    state_t            state, state_nx;
    logic [31:0]       hold;
    logic [CNT_W-1:0]  cnt;

    logic [1:0]        off;
    logic [WORD_W-1:0] word, word_nx;
    logic [3:0]        size_mask;
    logic [7:0]        mask8;
    logic [63:0]       wide;
    logic              illegal, split;
    logic [31:0]       rd_shift, merged;
    logic              start_split, finish_split;

    // Truncate to the access size, then sign- or zero-extend.
    function automatic logic [31:0] extend(input logic [31:0] v, input logic [2:0] f3);
        logic [31:0] r;
        case (f3)
            3'b000:  r = {{24{v[7]}}, v[7:0]};
            3'b001:  r = {{16{v[15]}}, v[15:0]};
            3'b100:  r = {24'b0, v[7:0]};
            3'b101:  r = {16'b0, v[15:0]};
            default: r = v;
        endcase
        return r;
    endfunction

    // Request decode and lane alignment.
    always_comb begin
        off  = req_addr[1:0];
        word = req_addr[ADDR_W-1:2];
        // Word index wraps naturally at 2^WORD_W.
        word_nx = word + {{(WORD_W-1){1'b0}}, 1'b1};

        case (req_f3[1:0])
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase

        // 8-bit mask / 64-bit data: low half feeds the first access, high
        // half the second.
        mask8 = {4'b0000, size_mask} << off;
        wide  = {32'b0, req_wdata} << {off, 3'b000};

        illegal = (req_f3 == 3'b011) || (req_f3 == 3'b110) || (req_f3 == 3'b111) ||
                  (req_write && req_f3[2]);
        split   = ((req_f3[1:0] == 2'b01) && (off == 2'b11)) ||
                  ((req_f3[1:0] == 2'b10) && (off != 2'b00));

        rd_shift = mem_rdata >> {off, 3'b000};
        // off is never 0 in SECOND, so the shift is 8..24.
        merged   = hold | (mem_rdata << (6'd32 - {1'b0, off, 3'b000}));
    end

    // Next state and outputs.
    always_comb begin
        state_nx     = state;
        start_split  = 1'b0;
        finish_split = 1'b0;
        stall        = 1'b0;
        done         = 1'b0;
        err          = 1'b0;
        load_data    = 32'h0;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_be       = 4'b0000;
        mem_wdata    = 32'h0;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (illegal) begin
                        err  = 1'b1;
                        done = 1'b1;
                    end else begin
                        mem_en    = 1'b1;
                        mem_we    = req_write;
                        mem_addr  = word;
                        mem_be    = mask8[3:0];
                        mem_wdata = req_write ? wide[31:0] : 32'h0;
                        if (split) begin
                            stall       = 1'b1;
                            start_split = 1'b1;
                            state_nx    = SECOND;
                        end else begin
                            done      = 1'b1;
                            load_data = req_write ? 32'h0 : extend(rd_shift, req_f3);
                        end
                    end
                end
            end
            SECOND: begin
                // Completes even if req_valid dropped; req_* are still held.
                mem_en       = 1'b1;
                mem_we       = req_write;
                mem_addr     = word_nx;
                mem_be       = mask8[7:4];
                mem_wdata    = req_write ? wide[63:32] : 32'h0;
                done         = 1'b1;
                load_data    = req_write ? 32'h0 : extend(merged, req_f3);
                finish_split = 1'b1;
                state_nx     = IDLE;
            end
            default: state_nx = IDLE;
        endcase

        // Reset silences every strobe, including a pending second access.
        if (!rst) begin
            stall     = 1'b0;
            done      = 1'b0;
            err       = 1'b0;
            load_data = 32'h0;
            mem_en    = 1'b0;
            mem_we    = 1'b0;
            mem_addr  = '0;
            mem_be    = 4'b0000;
            mem_wdata = 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            hold  <= 32'h0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (start_split)
                hold <= rd_shift;
            if (finish_split && (cnt != {CNT_W{1'b1}}))
                cnt <= cnt + 1'b1;
        end
    end

    assign split_cnt = cnt;

endmodule

// File: tb/tb_lsu_align.sv
module tb_lsu_align;

    logic        clk;
    logic        rst;
    logic        mem_init;
    logic        req_valid, req_write;
    logic [2:0]  req_f3;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic        stall, done, err, mem_en, mem_we;
    logic [31:0] load_data, mem_wdata, mem_rdata;
    logic [15:0] split_cnt;
    logic [7:0]  mem_addr;
    logic [3:0]  mem_be;

    // Small-counter instance for the saturation check.
    logic        s_valid;
    logic [31:0] s_rdata;
    logic        s_stall, s_done, s_err, s_mem_en, s_mem_we;
    logic [31:0] s_load_data, s_mem_wdata;
    logic [2:0]  s_cnt;
    logic [7:0]  s_mem_addr;
    logic [3:0]  s_mem_be;

    logic [31:0] mem [0:255];
    int          n_vec;
    int          n_err;
    logic [80:0] exp_v;
    wire  [80:0] obs = {stall, done, err, mem_en, mem_we, mem_be, mem_addr, mem_wdata, load_data};

    lsu_align #(.ADDR_W(10), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write), .req_f3(req_f3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .done(done), .err(err), .load_data(load_data),
        .split_cnt(split_cnt),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    lsu_align #(.ADDR_W(10), .CNT_W(3)) dut_sat (
        .clk(clk), .rst(rst),
        .req_valid(s_valid), .req_write(1'b0), .req_f3(3'b010),
        .req_addr(10'h001), .req_wdata(32'h0),
        .stall(s_stall), .done(s_done), .err(s_err), .load_data(s_load_data),
        .split_cnt(s_cnt),
        .mem_en(s_mem_en), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_be(s_mem_be),
        .mem_wdata(s_mem_wdata), .mem_rdata(s_rdata)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- memory model ----------------
    assign mem_rdata = mem[mem_addr];
    assign s_rdata   = 32'h0;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[4] <= 32'h44332211;
            mem[5] <= 32'h88776655;
            mem[6] <= 32'h00000099;
        end else if (mem_en && mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_req(input logic w, input logic [2:0] f3,
                             input logic [9:0] a, input logic [31:0] d);
        req_valid = 1'b1;
        req_write = w;
        req_f3    = f3;
        req_addr  = a;
        req_wdata = d;
    endtask

    task automatic drive_idle();
        req_valid = 1'b0;
        req_write = 1'b0;
        req_f3    = 3'b000;
        req_addr  = 10'h0;
        req_wdata = 32'h0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0; mem_init = 1'b1;
        drive_req(1'b0, 3'b010, 10'h012, 32'h0);
        @(negedge clk); @(negedge clk); #1;
        exp_v = '0;
        n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL reset_outputs obs=%h exp=%h", obs, exp_v); end
        n_vec++;
        if (split_cnt !== 16'h0) begin n_err++; $display("FAIL reset_cnt got=%h exp=0", split_cnt); end
        @(negedge clk);
        rst = 1'b1; mem_init = 1'b0; drive_idle();
        #1;
        n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL idle_outputs obs=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_split_load();
        @(negedge clk); drive_req(1'b0, 3'b010, 10'h012, 32'h0); #1;
        exp_v = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1100, 8'd4, 32'h0, 32'h0};
        n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL lw012_c0 obs=%h exp=%h", obs, exp_v); end
        @(negedge clk); #1;
        exp_v = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0011, 8'd5, 32'h0, 32'h66554433};
        n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL lw012_c1 obs=%h exp=%h", obs, exp_v); end
        @(negedge clk); drive_idle(); #1;
        n_vec++;
        if (split_cnt !== 16'd1) begin n_err++; $display("FAIL lw012_cnt got=%h exp=1", split_cnt); end
    endtask

    task automatic test_single_load();
        @(negedge clk); drive_req(1'b0, 3'b000, 10'h017, 32'h0); #1;
        exp_v = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1000, 8'd5, 32'h0, 32'hFFFFFF88};
        n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL lb017 obs=%h exp=%h", obs, exp_v); end
        @(negedge clk); drive_req(1'b0, 3'b100, 10'h017, 32'h0); #1;
        exp_v = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1000, 8'd5, 32'h0, 32'h00000088};
        n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL lbu017 obs=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk); drive_req(1'b0, 3'b001, 10'h017, 32'h0); #1;
        exp_v = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1000, 8'd5, 32'h0, 32'h0};
        n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL lh017_c0 obs=%h exp=%h", obs, exp_v); end
        @(negedge clk); #1;
        exp_v = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0001, 8'd6, 32'h0, 32'hFFFF9988};
        n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL lh017_c1 obs=%h exp=%h", obs, exp_v); end
        @(negedge clk); drive_req(1'b0, 3'b101, 10'h013, 32'h0); #1;
        exp_v = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1000, 8'd4, 32'h0, 32'h0};
        n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL lhu013_c0 obs=%h exp=%h", obs, exp_v); end
        @(negedge clk); #1;
        exp_v = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0001, 8'd5, 32'h0, 32'h00005544};
        n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL lhu013_c1 obs=%h exp=%h", obs, exp_v); end
        @(negedge clk); drive_idle(); #1;
        n_vec++;
        if (split_cnt !== 16'd3) begin n_err++; $display("FAIL b2b_cnt got=%h exp=3", split_cnt); end
    endtask

    task automatic test_valid_drop();
        @(negedge clk); drive_req(1'b0, 3'b010, 10'h016, 32'h0); #1;
        exp_v = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1100, 8'd5, 32'h0, 32'h0};
        n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL lw016_c0 obs=%h exp=%h", obs, exp_v); end
        @(negedge clk); req_valid = 1'b0; #1;
        exp_v = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0011, 8'd6, 32'h0, 32'h00998877};
        n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL lw016_c1_novalid obs=%h exp=%h", obs, exp_v); end
        @(negedge clk); drive_idle(); #1;
        exp_v = '0;
        n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL lw016_idle obs=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_error();
        @(negedge clk); drive_req(1'b0, 3'b011, 10'h010, 32'h0); #1;
        exp_v = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 8'd0, 32'h0, 32'h0};
        n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL err_f3_011 obs=%h exp=%h", obs, exp_v); end
        @(negedge clk); drive_req(1'b1, 3'b100, 10'h013, 32'h12345678); #1;
        n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL err_store_bu obs=%h exp=%h", obs, exp_v); end
        @(negedge clk); drive_idle(); #1;
        exp_v = '0;
        n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL err_idle obs=%h exp=%h", obs, exp_v); end
        n_vec++;
        if (split_cnt !== 16'd4) begin n_err++; $display("FAIL err_cnt got=%h exp=4", split_cnt); end
    endtask

    task automatic test_store_wrap();
        @(negedge clk); drive_req(1'b1, 3'b010, 10'h3FF, 32'hAABBCCDD); #1;
        exp_v = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1000, 8'd255, 32'hDD000000, 32'h0};
        n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL sw3ff_c0 obs=%h exp=%h", obs, exp_v); end
        @(negedge clk); #1;
        exp_v = {1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0111, 8'd0, 32'h00AABBCC, 32'h0};
        n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL sw3ff_c1 obs=%h exp=%h", obs, exp_v); end
        @(negedge clk); drive_idle(); #1;
        n_vec++;
        if (mem[0] !== 32'h00AABBCC) begin n_err++; $display("FAIL sw3ff_word0 got=%h exp=00aabbcc", mem[0]); end
        n_vec++;
        if (mem[255] !== 32'hDD000000) begin n_err++; $display("FAIL sw3ff_word255 got=%h exp=dd000000", mem[255]); end
        n_vec++;
        if (split_cnt !== 16'd5) begin n_err++; $display("FAIL sw3ff_cnt got=%h exp=5", split_cnt); end
    endtask

    task automatic test_store_sub();
        @(negedge clk); drive_req(1'b1, 3'b001, 10'h012, 32'h0000BEEF); #1;
        exp_v = {1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1100, 8'd4, 32'hBEEF0000, 32'h0};
        n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL sh012 obs=%h exp=%h", obs, exp_v); end
        @(negedge clk); drive_req(1'b1, 3'b000, 10'h015, 32'h1234567A); #1;
        exp_v = {1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0010, 8'd5, 32'h34567A00, 32'h0};
        n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL sb015 obs=%h exp=%h", obs, exp_v); end
        n_vec++;
        if (mem[4] !== 32'hBEEF2211) begin n_err++; $display("FAIL sh012_word4 got=%h exp=beef2211", mem[4]); end
        @(negedge clk); drive_idle(); #1;
        n_vec++;
        if (mem[5] !== 32'h88777A55) begin n_err++; $display("FAIL sb015_word5 got=%h exp=88777a55", mem[5]); end
    endtask

    task automatic test_reset_mid_split();
        @(negedge clk); drive_req(1'b1, 3'b010, 10'h011, 32'h12345678); #1;
        exp_v = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1110, 8'd4, 32'h34567800, 32'h0};
        n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL sw011_c0 obs=%h exp=%h", obs, exp_v); end
        @(negedge clk); rst = 1'b0; #1;
        exp_v = '0;
        n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL sw011_rst_outputs obs=%h exp=%h", obs, exp_v); end
        @(negedge clk); rst = 1'b1; drive_req(1'b0, 3'b010, 10'h010, 32'h0); #1;
        exp_v = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1111, 8'd4, 32'h0, 32'h34567811};
        n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL post_rst_lw010 obs=%h exp=%h", obs, exp_v); end
        n_vec++;
        if (split_cnt !== 16'd0) begin n_err++; $display("FAIL post_rst_cnt got=%h exp=0", split_cnt); end
        n_vec++;
        if (mem[5] !== 32'h88777A55) begin n_err++; $display("FAIL post_rst_word5 got=%h exp=88777a55", mem[5]); end
        @(negedge clk); drive_idle();
    endtask

    task automatic test_saturation();
        logic [2:0] exp_cnt;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk); s_valid = 1'b1;
            @(negedge clk);
            @(negedge clk); s_valid = 1'b0; #1;
            exp_cnt = (i + 1 > 7) ? 3'd7 : 3'(i + 1);
            n_vec++;
            if (s_cnt !== exp_cnt) begin
                n_err++;
                $display("FAIL sat_cnt_%0d got=%h exp=%h", i, s_cnt, exp_cnt);
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        n_vec = 0;
        n_err = 0;
        s_valid = 1'b0;
        test_reset();
        test_split_load();
        test_single_load();
        test_back_to_back();
        test_valid_drop();
        test_error();
        test_store_wrap();
        test_store_sub();
        test_reset_mid_split();
        test_saturation();
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/lsu_align.md
# lsu_align

Load/store alignment unit between the MEM-stage pipeline register and the data memory. It turns a pipeline request (byte address plus funct3 width/sign) into word-aligned memory accesses with byte enables. Accesses that cross a 32-bit word boundary are split into two back-to-back accesses while the pipeline is stalled. Load bytes are extracted, merged, and sign- or zero-extended before write-back.

## Interface
Parameters:
- ADDR_W, 10: byte-address width; word index is ADDR_W-2 bits.
- CNT_W, 16: width of the split-access counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset: one clock; reset is synchronous and active-low.
- req_valid  in  1  MEM-stage request present this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_f3  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU are loads only).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data (rs2).
- stall  out  1  holds the pipeline; all req_* inputs must stay stable while it is 1.
- done  out  1  request completes this cycle.
- err  out  1  illegal request this cycle; no memory access is made.
- load_data  out  32  extended load result; valid only when done=1 and req_write=0, otherwise 0.
- split_cnt  out  CNT_W  saturating count of split requests.
- mem_en  out  1  memory access this cycle.
- mem_we  out  1  write strobe.
- mem_addr  out  ADDR_W-2  word index.
- mem_be  out  4  byte enables; bit i selects bits [8i+7:8i].
- mem_wdata  out  32  lane-aligned write data.
- mem_rdata  in  32  combinational read data for mem_addr.

## Operation
- off = req_addr[1:0]; size = 1 (B/BU), 2 (H/HU), 4 (W).
- Split condition: off + size > 4, i.e. H/HU with off=3, or W with off≠0.
- Illegal conditions:
  - req_f3 ∈ {011, 110, 111}.
  - req_write=1 with req_f3 ∈ {100, 101}.
  - Response: err=1, done=1, stall=0, mem_en=0, load_data=0. No state change.
- Store lanes:
  - Form the 64-bit value {32'b0, req_wdata} << 8·off and the 8-bit mask ((1<<size)-1) << off.
  - First access uses the low 32 bits and mask[3:0].
  - Second access uses the high 32 bits and mask[7:4].
- Load merge:
  - First access captures mem_rdata >> 8·off into a 32-bit hold register.
  - Second access result = hold | (mem_rdata << 8·(4-off)).
  - The result is truncated to size bytes, then sign-extended (B, H) or zero-extended (BU, HU, W).
- FSM, two states:
  - IDLE:
    - With req_valid and legal, non-split: one access at word addr[ADDR_W-1:2]; done=1, stall=0; stay in IDLE.
    - With req_valid and split: first access at word w = addr[ADDR_W-1:2]; stall=1, done=0; capture hold; go to SECOND.
  - SECOND: access word w+1 modulo 2^(ADDR_W-2); done=1, stall=0; split_cnt += 1, saturating at all-ones; go to IDLE.
- Word 2^(ADDR_W-2)-1 plus one wraps to word 0.
- A split store writes the first half in cycle 0 and the second half in cycle 1. The pair is not atomic.
- req_valid=0 in IDLE: all outputs are 0 except split_cnt.

## Timing
- Reset values (rst=0 at a clock edge):
  - State IDLE, hold = 0, split_cnt = 0.
  - While rst=0, all outputs are forced to 0: stall, done, err, mem_en, mem_we, mem_be, mem_wdata, mem_addr, load_data.
- Latency:
  - Non-split: 0 cycles; done and memory strobes are combinational in the request cycle.
  - Split: 1 stall cycle; done in the second cycle.
- mem_rdata is sampled in the same cycle mem_en=1. The memory writes on the rising edge following mem_we=1.
- Reset during SECOND: return to IDLE with no second access. A first-half store already written remains in memory. split_cnt is cleared.
- req_valid deasserted during SECOND (protocol violation): the second access still completes using the held inputs.
- Back-to-back requests: a new request is accepted in the cycle after done with no bubble.

## Test plan
Preload word 4 = 0x44332211, word 5 = 0x88776655, word 6 = 0x00000099.
- LW addr 0x012 -> cycle 0: stall=1, mem_addr=4; cycle 1: mem_addr=5, done=1, load_data=0x66554433, split_cnt=1.
- LB 0x017 -> single cycle, done=1, stall=0, load_data=0xFFFFFF88. LBU 0x017 -> 0x00000088.
- LH 0x017 -> split over words 5 and 6, load_data=0xFFFF9988. LHU 0x013 -> load_data=0x00005544, split_cnt increments.
- SW 0xAABBCCDD to 0x3FF -> cycle 0: word 255, be=1000, wdata[31:24]=0xDD; cycle 1: word 0 (wrap), be=0111, word 0 low 3 bytes = 0xAABBCC.
- SH 0xBEEF to 0x012 -> single cycle, be=1100, word 4 = 0xBEEF2211. Then SB 0x7A to 0x015 -> be=0010, word 5 = 0x88777A55.
- Error and reset:
  - req_f3=011 -> err=1, mem_en=0.
  - rst=0 asserted during SECOND of an SW split to 0x011 -> only word 4 is modified, state returns to IDLE, next request proceeds normally.
  - split_cnt forced near saturation -> it holds at 0xFFFF.
